plot_sweep_scheduler: RTL and testbench

Sequences one full-screen plot pass for the 96x64 OLED graph path. For each display column it computes the column's x-value and, in ascending index order, requests one y-value evaluation per enabled function channel. It converts each returned y to a screen row and issues one frame-buffer pixel write per on-screen result. It sits between the top-level plot control (start/continuous) and the shared function evaluator and frame-buffer write port.

---
 rtl/plot_sweep_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_plot_sweep_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sweep_scheduler.sv
// Purpose : sequences one full-screen plot pass; per column computes x, asks the shared
//           evaluator for y on each enabled channel, maps y to a row, writes on-screen pixels.
// Latency : 1 cycle COL_START per column, >=2 cycles per evaluation, >=1 cycle per write,
//           1 cycle ADVANCE per channel slot; frame_done one cycle after the last column.
// Backpressure: eval_req_o held until eval_valid_i; fb_wr_valid_o held (fields stable) until
//           fb_wr_ready_i. The two handshakes are never active in the same cycle.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i, continuous_i   begin a sweep (IDLE only) / auto-restart (sampled in DONE only)
//   ch_enable_i             per-channel enable, latched at the start of every column
//   busy_o, frame_done_o    status: not IDLE / one-cycle end-of-frame pulse
//   col_o                   current column
//   eval_req_o, eval_x_o, eval_ch_o, eval_valid_i, eval_y_i   evaluator request/response
//   fb_wr_valid_o, fb_wr_ready_i, fb_wr_col_o, fb_wr_row_o, fb_wr_ch_o   pixel write port
//   timeout_flag_o          sticky evaluator-timeout flag (only with SCHED_TIMEOUT_EN)
//
// Build option: define SCHED_TIMEOUT_EN to abandon an evaluation after TIMEOUT_CYCLES
// cycles in WAIT. Without it WAIT holds until the evaluator answers.

module plot_sweep_scheduler #(
    parameter int MIN_X          = -180,
    parameter int MAX_X          = 179,
    parameter int NUM_COLS       = 96,
    parameter int NUM_ROWS       = 64,
    parameter int Y_ORIGIN       = 31,
    parameter int N_CH           = 3,
    parameter int CHW            = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   continuous_i,
    input  logic [N_CH-1:0]        ch_enable_i,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [6:0]             col_o,
    output logic                   eval_req_o,
    output logic signed [9:0]      eval_x_o,
    output logic [CHW-1:0]         eval_ch_o,
    input  logic                   eval_valid_i,
    input  logic signed [9:0]      eval_y_i,
    output logic                   fb_wr_valid_o,
    input  logic                   fb_wr_ready_i,
    output logic [6:0]             fb_wr_col_o,
    output logic [5:0]             fb_wr_row_o,
    output logic [CHW-1:0]         fb_wr_ch_o
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic                   timeout_flag_o
`endif
);

    localparam int SPAN = MAX_X - MIN_X + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COL_START,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_ADVANCE,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [6:0]            col_q, col_d;
    logic [N_CH-1:0]       mask_q, mask_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic signed [9:0]     eval_x_q, eval_x_d;
    logic [5:0]            row_q, row_d;
`ifdef SCHED_TIMEOUT_EN
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  tmo_flag_q, tmo_flag_d;
`endif

    // ------------------------------------------------------------------
    // Column -> x mapping. The product col*span needs 16 bits unsigned
    // (95*360 = 34200); the sum wraps to the 10-bit signed x naturally
    // because MIN_X is added in two's complement.
    // ------------------------------------------------------------------
    logic [9:0] col_x_w;
    assign col_x_w = 10'(16'(MIN_X) + (16'(col_q) * 16'(SPAN)) / 16'(NUM_COLS));

    // ------------------------------------------------------------------
    // y -> row mapping at 11 bits so that both overflow directions are
    // visible as either a negative value or a value >= NUM_ROWS.
    // ------------------------------------------------------------------
    logic [10:0] row_w;
    logic        row_ok_w;
    assign row_w    = 11'(Y_ORIGIN) - {eval_y_i[9], eval_y_i};
    assign row_ok_w = !row_w[10] && (row_w[9:0] < 10'(NUM_ROWS));

    // ------------------------------------------------------------------
    // Channel selection: lowest set bit of the incoming enables (used while
    // the mask is being latched) and next set bit above the current channel.
    // Loops run downwards so the lowest qualifying index wins.
    // ------------------------------------------------------------------
    logic [CHW-1:0] first_ch_w;
    logic           next_vld_w;
    logic [CHW-1:0] next_ch_w;

    always_comb begin
        first_ch_w = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_enable_i[i]) begin
                first_ch_w = CHW'(i);
            end
        end
    end

    always_comb begin
        next_vld_w = 1'b0;
        next_ch_w  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_vld_w = 1'b1;
                next_ch_w  = CHW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        eval_x_d = eval_x_q;
        row_d    = row_q;
`ifdef SCHED_TIMEOUT_EN
        tmo_cnt_d  = '0;
        tmo_flag_d = tmo_flag_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COL_START;
                    col_d   = '0;
`ifdef SCHED_TIMEOUT_EN
                    tmo_flag_d = 1'b0;
`endif
                end
            end

            S_COL_START: begin
                // Enables are sampled once per column so a mid-column change
                // cannot reorder or duplicate channels within that column.
                mask_d   = ch_enable_i;
                eval_x_d = $signed(col_x_w);
                if (|ch_enable_i) begin
                    ch_d    = first_ch_w;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_ADVANCE;
                end
            end

            // First request cycle; the evaluator cannot answer before the
            // following cycle, so the response is only looked at in WAIT.
            S_ISSUE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (eval_valid_i) begin
                    if (row_ok_w) begin
                        row_d   = row_w[5:0];
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ADVANCE;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // Counter value N-1 marks the N-th WAIT cycle.
                    tmo_flag_d = 1'b1;
                    state_d    = S_ADVANCE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end

            S_WRITE: begin
                if (fb_wr_ready_i) begin
                    state_d = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                if (next_vld_w) begin
                    ch_d    = next_ch_w;
                    state_d = S_ISSUE;
                end else if (col_q == 7'(NUM_COLS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    col_d   = col_q + 7'd1;
                    state_d = S_COL_START;
                end
            end

            S_DONE: begin
                if (continuous_i) begin
                    col_d   = '0;
                    state_d = S_COL_START;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            mask_q   <= '0;
            ch_q     <= '0;
            eval_x_q <= '0;
            row_q    <= '0;
`ifdef SCHED_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            eval_x_q <= eval_x_d;
            row_q    <= row_d;
`ifdef SCHED_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: handshake strobes decode directly from the state register,
    // so they are glitch-free and drop to 0 the moment reset asserts.
    // ------------------------------------------------------------------
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = (state_q == S_DONE);
    assign eval_req_o    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign fb_wr_valid_o = (state_q == S_WRITE);

    assign col_o       = col_q;
    assign eval_x_o    = eval_x_q;
    assign eval_ch_o   = ch_q;
    assign fb_wr_col_o = col_q;
    assign fb_wr_row_o = row_q;
    assign fb_wr_ch_o  = ch_q;
`ifdef SCHED_TIMEOUT_EN
    assign timeout_flag_o = tmo_flag_q;
`endif

endmodule

// File: tb/tb_plot_sweep_scheduler.sv
// Bench for plot_sweep_scheduler: table of frame scenarios plus hand-written
// sequences for continuous restart, asynchronous reset mid-WAIT and timeout.
module tb_plot_sweep_scheduler;

    localparam int NC = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic              continuous;
    logic [2:0]        ch_enable;
    logic              busy;
    logic              frame_done;
    logic [6:0]        col;
    logic              eval_req;
    logic signed [9:0] eval_x;
    logic [1:0]        eval_ch;
    logic              eval_valid;
    logic signed [9:0] eval_y;
    logic              fb_wr_valid;
    logic              fb_wr_ready;
    logic [6:0]        fb_wr_col;
    logic [5:0]        fb_wr_row;
    logic [1:0]        fb_wr_ch;
`ifdef SCHED_TIMEOUT_EN
    logic              timeout_flag;
`endif

    plot_sweep_scheduler dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .continuous_i  (continuous),
        .ch_enable_i   (ch_enable),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .col_o         (col),
        .eval_req_o    (eval_req),
        .eval_x_o      (eval_x),
        .eval_ch_o     (eval_ch),
        .eval_valid_i  (eval_valid),
        .eval_y_i      (eval_y),
        .fb_wr_valid_o (fb_wr_valid),
        .fb_wr_ready_i (fb_wr_ready),
        .fb_wr_col_o   (fb_wr_col),
        .fb_wr_row_o   (fb_wr_row),
        .fb_wr_ch_o    (fb_wr_ch)
`ifdef SCHED_TIMEOUT_EN
        ,
        .timeout_flag_o(timeout_flag)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string      name;
        logic [2:0] en;
        int         mode;     // evaluator y function
        int         lat;      // request cycles until eval_valid (>=2)
        int         stall;    // cycles of fb_wr_ready low per write
        int         exp_wr;
        int         exp_req;
        int         exp_req_ch1;
        int         exp_frow;
        int         exp_lrow;
        int         exp_fcol;
        int         exp_lcol;
        int         exp_hold; // cycles fb_wr_valid is high per write
    } vec_t;

    typedef struct {
        int c;
        int r;
        int ch;
    } wr_t;

    // ---------------- models and statistics ----------------
    int  cfg_mode, cfg_lat, cfg_stall;
    int  req_age = 0, wr_age = 0;
    int  n_writes, n_reqs, seq_err, x_err, hold_err, overlap, req_overrun, max_hold, done_cnt;
    int  first_row, last_row, first_col, last_col;
    int  n_reqs_ch[4];
    int  xs[NC];
    logic signed [9:0] req_x;
    logic [1:0]        req_ch;
    logic [6:0]        w_col;
    logic [5:0]        w_row;
    logic [1:0]        w_ch;
    wr_t exp_q[$];

    function automatic int y_of(input int mode, input int ch, input int c, input int x);
        case (mode)
            0:       return 0;
            1:       return ch * 5;
            2:       return (c % 2 == 0) ? 32 : -32;
            3:       return x / 6;
            default: return 0;
        endcase
    endfunction

    function automatic int x_of(input int c);
        return -180 + (c * 360) / 96;
    endfunction

    task automatic clear_stats();
        n_writes = 0; n_reqs = 0; seq_err = 0; x_err = 0; hold_err = 0;
        overlap = 0; req_overrun = 0; max_hold = 0; done_cnt = 0;
        first_row = -1; last_row = -1; first_col = -1; last_col = -1;
        for (int i = 0; i < 4; i++) n_reqs_ch[i] = 0;
        exp_q.delete();
    endtask

    task automatic build_expected(input logic [2:0] en, input int mode);
        wr_t w;
        for (int c = 0; c < NC; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (en[ch]) begin
                    w.c  = c;
                    w.ch = ch;
                    w.r  = 31 - y_of(mode, ch, c, x_of(c));
                    if (w.r >= 0 && w.r <= 63) exp_q.push_back(w);
                end
            end
        end
    endtask

    // One cycle: sample at negedge, run evaluator and frame-buffer models,
    // drive their inputs for the next rising edge.
    task automatic step();
        wr_t w;
        @(negedge clk);
        if (eval_req && fb_wr_valid) overlap++;
        if (frame_done) done_cnt++;

        if (eval_req) begin
            req_age++;
            if (req_age == 1) begin
                n_reqs++;
                n_reqs_ch[eval_ch]++;
                req_x  = eval_x;
                req_ch = eval_ch;
                if (int'(col) < NC) xs[col] = int'(eval_x);
                if (int'(eval_x) != x_of(int'(col))) x_err++;
            end else if (eval_x != req_x || eval_ch != req_ch) begin
                hold_err++;
            end
            if (req_age > cfg_lat) req_overrun++;
            eval_valid = (req_age == cfg_lat);
            eval_y     = 10'(y_of(cfg_mode, int'(eval_ch), int'(col), int'(eval_x)));
        end else begin
            req_age    = 0;
            eval_valid = 1'b0;
        end

        if (fb_wr_valid) begin
            wr_age++;
            if (wr_age == 1) begin
                w_col = fb_wr_col; w_row = fb_wr_row; w_ch = fb_wr_ch;
            end else if (fb_wr_col != w_col || fb_wr_row != w_row || fb_wr_ch != w_ch) begin
                hold_err++;
            end
            fb_wr_ready = (wr_age > cfg_stall);
            if (fb_wr_ready) begin
                n_writes++;
                if (wr_age > max_hold) max_hold = wr_age;
                if (n_writes == 1) begin
                    first_row = int'(fb_wr_row);
                    first_col = int'(fb_wr_col);
                end
                last_row = int'(fb_wr_row);
                last_col = int'(fb_wr_col);
                if (exp_q.size() == 0) begin
                    seq_err++;
                end else begin
                    w = exp_q.pop_front();
                    if (w.c != int'(fb_wr_col) || w.r != int'(fb_wr_row) || w.ch != int'(fb_wr_ch))
                        seq_err++;
                end
            end
        end else begin
            wr_age      = 0;
            fb_wr_ready = 1'b0;
        end
    endtask

    task automatic run_frame(input vec_t v);
        clear_stats();
        build_expected(v.en, v.mode);
        cfg_mode  = v.mode;
        cfg_lat   = v.lat;
        cfg_stall = v.stall;
        ch_enable = v.en;
        start     = 1'b1;
        step();
        start     = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) step();
        step();
        check({v.name, ":busy_after"},   int'(busy), 0);
        check({v.name, ":done_pulses"},  done_cnt, 1);
        check({v.name, ":writes"},       n_writes, v.exp_wr);
        check({v.name, ":reqs"},         n_reqs, v.exp_req);
        check({v.name, ":reqs_ch1"},     n_reqs_ch[1], v.exp_req_ch1);
        check({v.name, ":seq_err"},      seq_err, 0);
        check({v.name, ":missing_wr"},   exp_q.size(), 0);
        check({v.name, ":x_err"},        x_err, 0);
        check({v.name, ":hold_err"},     hold_err, 0);
        check({v.name, ":req_wr_overlap"}, overlap, 0);
        check({v.name, ":req_overrun"},  req_overrun, 0);
        check({v.name, ":first_row"},    first_row, v.exp_frow);
        check({v.name, ":last_row"},     last_row, v.exp_lrow);
        check({v.name, ":first_col"},    first_col, v.exp_fcol);
        check({v.name, ":last_col"},     last_col, v.exp_lcol);
        check({v.name, ":hold_cycles"},  max_hold, v.exp_hold);
    endtask

    // Hard stop in case a sequence wedges outside its own cycle budgets.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];

    initial begin
        int cnt;
        //               name     en      mode lat stall wr   req  ch1 frow lrow fcol lcol hold
        vecs[0] = '{"basic",  3'b001, 0, 2, 0,  96,  96,  0, 31,  31,  0,  95, 1};
        vecs[1] = '{"multi",  3'b101, 1, 2, 0, 192, 192,  0, 31,  21,  0,  95, 1};
        vecs[2] = '{"clip",   3'b001, 2, 3, 0,  48,  96,  0, 63,  63,  1,  95, 1};
        vecs[3] = '{"bp",     3'b001, 0, 2, 5,  96,  96,  0, 31,  31,  0,  95, 6};
        vecs[4] = '{"ramp",   3'b010, 3, 4, 1,  96,  96, 96, 61,   2,  0,  95, 2};
        vecs[5] = '{"none",   3'b000, 0, 2, 0,   0,   0,  0, -1,  -1, -1,  -1, 0};
        vecs[6] = '{"all",    3'b111, 1, 2, 0, 288, 288, 96, 31,  21,  0,  95, 1};

        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_enable = 3'b000;
        eval_valid = 1'b0; eval_y = '0; fb_wr_ready = 1'b0;
        cfg_mode = 0; cfg_lat = 2; cfg_stall = 0;
        clear_stats();

        repeat (3) @(negedge clk);
        check("rst:busy",        int'(busy), 0);
        check("rst:frame_done",  int'(frame_done), 0);
        check("rst:eval_req",    int'(eval_req), 0);
        check("rst:fb_wr_valid", int'(fb_wr_valid), 0);
        check("rst:col",         int'(col), 0);
        check("rst:eval_x",      int'(eval_x), 0);
        check("rst:eval_ch",     int'(eval_ch), 0);
        check("rst:fb_wr_row",   int'(fb_wr_row), 0);
`ifdef SCHED_TIMEOUT_EN
        check("rst:timeout_flag", int'(timeout_flag), 0);
`endif
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Last frame requested every column: x table endpoints.
        check("x_col0",  xs[0],  -180);
        check("x_col1",  xs[1],  -177);
        check("x_col2",  xs[2],  -173);
        check("x_col95", xs[95],  176);

        // ---- continuous restart ----
        clear_stats();
        cfg_mode = 0; cfg_lat = 2; cfg_stall = 0;
        ch_enable = 3'b001; continuous = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4000 && !frame_done; i++) step();
        check("cont:done_seen", int'(frame_done), 1);
        step();
        check("cont:col_restart", int'(col), 0);
        check("cont:busy",        int'(busy), 1);
        check("cont:done_width",  int'(frame_done), 0);
        continuous = 1'b0;

        // ---- async reset while waiting on column 40 ----
        cfg_lat = 6;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (col == 7'd40 && eval_req && req_age >= 3) break;
        end
        check("rstw:in_wait_col40", int'(col == 7'd40 && eval_req), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstw:busy",        int'(busy), 0);
        check("rstw:eval_req",    int'(eval_req), 0);
        check("rstw:fb_wr_valid", int'(fb_wr_valid), 0);
        check("rstw:col",         int'(col), 0);
        check("rstw:eval_x",      int'(eval_x), 0);
        check("rstw:frame_done",  int'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        eval_valid = 1'b1;
        eval_y = '0;
        @(negedge clk);
        eval_valid = 1'b0;
        clear_stats();
        repeat (10) step();
        check("late:busy",   int'(busy), 0);
        check("late:reqs",   n_reqs, 0);
        check("late:writes", n_writes, 0);

`ifdef SCHED_TIMEOUT_EN
        // ---- evaluator silent on ch0 col0 ----
        clear_stats();
        cfg_lat = 100000; ch_enable = 3'b001;
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (eval_req) cnt++;
            else if (cnt > 0) break;
        end
        check("tmo:req_cycles", cnt, 256);
        check("tmo:flag",       int'(timeout_flag), 1);
        for (int i = 0; i < 10 && !eval_req; i++) step();
        check("tmo:next_col",   int'(col), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`else
        cnt = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
